// File: rtl/int_pkg.sv
// Shared types, constants and the highest-set-bit helper for the interrupt controller.
package int_pkg;

    localparam int unsigned NSRC = 3;
    localparam int unsigned IDW  = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    localparam logic [IDW-1:0] SRC0 = 2'd0;
    localparam logic [IDW-1:0] SRC1 = 2'd1;
    localparam logic [IDW-1:0] SRC2 = 2'd2;

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] idx;
    } hsb_t;

    // Index of the highest set bit; valid=0 when the vector is empty.
    function automatic hsb_t hsb(input logic [NSRC-1:0] v);
        hsb_t r;
        r.valid = 1'b0;
        r.idx   = SRC0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (v[i]) begin
                r.valid = 1'b1;
                r.idx   = IDW'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/int_ctrl_edge_detect.sv
// Samples the raw request lines once and flags rising edges against the sampled copy.
module int_ctrl_edge_detect #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_in,
    output logic [W-1:0] o_rise_c
);

    logic [W-1:0] r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= '0;
        end else begin
            r_prev <= i_in;
        end
    end

    assign o_rise_c = i_in & ~r_prev;

endmodule

// File: rtl/int_ctrl.sv
// Nested, fixed-priority interrupt request controller closing the loop on MEM-stage entry/uret retirement.
module int_ctrl
    import int_pkg::*;
#(
    parameter int unsigned     WIDTH      = 32,
    parameter logic [WIDTH-1:0] VEC_BASE   = WIDTH'(32'h0000_0100),
    parameter logic [WIDTH-1:0] VEC_STRIDE = WIDTH'(32'h0000_0040),
    parameter logic [WIDTH-1:0] CAUSE_BASE = WIDTH'(32'h8000_0010)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NSRC-1:0]  irq_in,
    input  logic             ie,
    input  logic             int_ack,
    input  logic             uret_ack,
    output logic             int_req,
    output logic [IDW-1:0]   int_id,
    output logic [WIDTH-1:0] int_vec,
    output logic [WIDTH-1:0] int_cause,
    output logic [NSRC-1:0]  IRS,
    output logic [NSRC-1:0]  pending
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_req;
    logic             w_req_nxt;
    logic [IDW-1:0]   r_id;
    logic [IDW-1:0]   w_id_nxt;
    logic [WIDTH-1:0] r_vec;
    logic [WIDTH-1:0] w_vec_nxt;
    logic [WIDTH-1:0] r_cause;
    logic [WIDTH-1:0] w_cause_nxt;
    logic [NSRC-1:0]  r_irs;
    logic [NSRC-1:0]  w_irs_nxt;
    logic [NSRC-1:0]  r_pend;
    logic [NSRC-1:0]  w_pend_nxt;
    logic [NSRC-1:0]  w_rise;
    logic [NSRC-1:0]  w_elig;
    hsb_t             w_lvl;
    hsb_t             w_win;

    int_ctrl_edge_detect #(
        .W (NSRC)
    ) u_edge (
        .clk      (clk),
        .rst      (rst),
        .i_in     (irq_in),
        .o_rise_c (w_rise)
    );

    // Only sources strictly above the current in-service level may be requested.
    always_comb begin
        w_lvl  = hsb(r_irs);
        w_elig = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (!w_lvl.valid || (IDW'(i) > w_lvl.idx)) begin
                w_elig[i] = r_pend[i];
            end
        end
        w_win = hsb(w_elig);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_id    <= SRC0;
            r_vec   <= VEC_BASE;
            r_cause <= CAUSE_BASE;
            r_irs   <= '0;
            r_pend  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_id    <= w_id_nxt;
            r_vec   <= w_vec_nxt;
            r_cause <= w_cause_nxt;
            r_irs   <= w_irs_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    // uret clears on the old IRS first; an entry ack then sets its bit; new edges win over the pending clear.
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_id_nxt    = r_id;
        w_irs_nxt   = r_irs;
        w_pend_nxt  = r_pend;

        if (uret_ack && w_lvl.valid) begin
            w_irs_nxt[w_lvl.idx] = 1'b0;
        end

        case (r_state)
            ST_IDLE: begin
                if (ie && w_win.valid) begin
                    w_state_nxt = ST_REQ;
                    w_req_nxt   = 1'b1;
                    w_id_nxt    = w_win.idx;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    w_pend_nxt[r_id] = 1'b0;
                    w_irs_nxt[r_id]  = 1'b1;
                    w_req_nxt        = 1'b0;
                    w_state_nxt      = ST_IDLE;
                end else if (!ie) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_pend_nxt  = w_pend_nxt | w_rise;
        w_vec_nxt   = VEC_BASE + (WIDTH'(w_id_nxt) * VEC_STRIDE);
        w_cause_nxt = CAUSE_BASE + WIDTH'(w_id_nxt);
    end

    assign int_req   = r_req;
    assign int_id    = r_id;
    assign int_vec   = r_vec;
    assign int_cause = r_cause;
    assign IRS       = r_irs;
    assign pending   = r_pend;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: behavioural model compared every cycle plus literal spot checks.
module tb_int_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  irq_in;
    logic        ie;
    logic        int_ack;
    logic        uret_ack;
    logic        int_req;
    logic [1:0]  int_id;
    logic [31:0] int_vec;
    logic [31:0] int_cause;
    logic [2:0]  IRS;
    logic [2:0]  pending;

    int checks   = 0;
    int failures = 0;

    int_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .irq_in    (irq_in),
        .ie        (ie),
        .int_ack   (int_ack),
        .uret_ack  (uret_ack),
        .int_req   (int_req),
        .int_id    (int_id),
        .int_vec   (int_vec),
        .int_cause (int_cause),
        .IRS       (IRS),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: sets of pending/in-service sources and a single in-flight request.
    bit [2:0] m_prev, m_pend, m_irs;
    bit       m_busy;
    int       m_id;
    bit       m_started = 1'b0;

    always @(posedge clk) begin
        bit [2:0] rise, irs_n, pend_n;
        int top, win;
        if (rst) begin
            m_prev = '0; m_pend = '0; m_irs = '0; m_busy = 1'b0; m_id = 0;
        end else begin
            rise   = irq_in & ~m_prev;
            m_prev = irq_in;
            top = -1;
            for (int n = 0; n < 3; n++) if (m_irs[n]) top = n;
            irs_n  = m_irs;
            pend_n = m_pend;
            if (uret_ack && top >= 0) irs_n[top] = 1'b0;
            if (m_busy) begin
                if (int_ack) begin
                    pend_n[m_id] = 1'b0;
                    irs_n[m_id]  = 1'b1;
                    m_busy       = 1'b0;
                end else if (!ie) begin
                    m_busy = 1'b0;
                end
            end else begin
                win = -1;
                for (int n = 0; n < 3; n++) if (m_pend[n] && n > top) win = n;
                if (ie && win >= 0) begin
                    m_busy = 1'b1;
                    m_id   = win;
                end
            end
            m_pend = pend_n | rise;
            m_irs  = irs_n;
        end
        m_started = 1'b1;
    end

    always @(negedge clk) begin
        if (m_started) begin
            chk("int_req",   {31'd0, int_req}, {31'd0, m_busy});
            chk("int_id",    {30'd0, int_id},  32'(m_id));
            chk("int_vec",   int_vec,   32'h0000_0100 + 32'(m_id) * 32'h40);
            chk("int_cause", int_cause, 32'h8000_0010 + 32'(m_id));
            chk("IRS",       {29'd0, IRS},     {29'd0, m_irs});
            chk("pending",   {29'd0, pending}, {29'd0, m_pend});
            if (int_ack && !rst) chk("ack_outside_req", {31'd0, int_req}, 32'd1);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [2:0] v);
        irq_in = v; step(1);
        irq_in = 3'b000; step(1);
    endtask

    task automatic ack1();
        int_ack = 1'b1; step(1); int_ack = 1'b0;
    endtask

    task automatic uret1();
        uret_ack = 1'b1; step(1); uret_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq_in = 3'b000; ie = 1'b1; int_ack = 1'b0; uret_ack = 1'b0;
        step(2);
        chk("rst_req",   {31'd0, int_req}, 32'd0);
        chk("rst_vec",   int_vec,   32'h0000_0100);
        chk("rst_cause", int_cause, 32'h8000_0010);
        chk("rst_IRS",   {29'd0, IRS}, 32'd0);
        rst = 1'b0;
        step(1);

        // Basic entry of source 0
        pulse(3'b001);
        chk("t1_req",   {31'd0, int_req}, 32'd1);
        chk("t1_id",    {30'd0, int_id},  32'd0);
        chk("t1_vec",   int_vec,   32'h0000_0100);
        chk("t1_cause", int_cause, 32'h8000_0010);
        ack1();
        chk("t1_IRS",  {29'd0, IRS},     32'b001);
        chk("t1_pend", {29'd0, pending}, 32'd0);

        // Nesting: source 2 preempts source 0
        pulse(3'b100);
        chk("t2_req", {31'd0, int_req}, 32'd1);
        chk("t2_id",  {30'd0, int_id},  32'd2);
        chk("t2_vec", int_vec, 32'h0000_0180);
        ack1();
        chk("t2_IRS_a", {29'd0, IRS}, 32'b101);
        uret1();
        chk("t2_IRS_b", {29'd0, IRS}, 32'b001);
        uret1();
        chk("t2_IRS_c", {29'd0, IRS}, 32'd0);

        // Lower source blocked by in-service source 2
        pulse(3'b100); ack1();
        pulse(3'b010); step(1);
        chk("t3_pend", {29'd0, pending}, 32'b010);
        chk("t3_req0", {31'd0, int_req}, 32'd0);
        uret1();
        chk("t3_IRS",  {29'd0, IRS},     32'd0);
        chk("t3_req1", {31'd0, int_req}, 32'd0);
        step(1);
        chk("t3_req2", {31'd0, int_req}, 32'd1);
        chk("t3_id",   {30'd0, int_id},  32'd1);
        ack1(); uret1();

        // Simultaneous edges on 0 and 2
        pulse(3'b101);
        chk("t4_id2", {30'd0, int_id}, 32'd2);
        ack1(); step(2);
        chk("t4_hold", {31'd0, int_req}, 32'd0);
        chk("t4_pend", {29'd0, pending}, 32'b001);
        uret1(); step(1);
        chk("t4_req", {31'd0, int_req}, 32'd1);
        chk("t4_id0", {30'd0, int_id},  32'd0);
        ack1(); uret1();

        // Withdraw on ie drop, re-request, then ack+uret together with a colliding edge
        pulse(3'b001); ack1();
        pulse(3'b100);
        ie = 1'b0; step(1);
        chk("t5_wd_req",  {31'd0, int_req}, 32'd0);
        chk("t5_wd_pend", {29'd0, pending}, 32'b100);
        ie = 1'b1; step(1);
        chk("t5_rereq", {31'd0, int_req}, 32'd1);
        chk("t5_reid",  {30'd0, int_id},  32'd2);
        irq_in = 3'b100; int_ack = 1'b1; uret_ack = 1'b1; step(1);
        irq_in = 3'b000; int_ack = 1'b0; uret_ack = 1'b0;
        chk("t5_IRS",  {29'd0, IRS},     32'b100);
        chk("t5_pend", {29'd0, pending}, 32'b100);
        step(1);
        chk("t5_noreq", {31'd0, int_req}, 32'd0);
        uret1(); step(1);
        chk("t5_req2", {31'd0, int_req}, 32'd1);
        ack1(); uret1();

        // Reset mid-request, line held high through reset
        irq_in = 3'b001; step(2);
        chk("t6_req", {31'd0, int_req}, 32'd1);
        rst = 1'b1; step(1);
        chk("t6_rst_req",  {31'd0, int_req}, 32'd0);
        chk("t6_rst_IRS",  {29'd0, IRS},     32'd0);
        chk("t6_rst_pend", {29'd0, pending}, 32'd0);
        rst = 1'b0; step(1);
        chk("t6_pend", {29'd0, pending}, 32'b001);
        step(1);
        chk("t6_req2", {31'd0, int_req}, 32'd1);
        ack1(); step(3);
        chk("t6_once", {31'd0, int_req}, 32'd0);
        chk("t6_IRS",  {29'd0, IRS},     32'b001);
        irq_in = 3'b000; uret1(); step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
